sram_1rw_req_adapter: RTL
=========================

Name: sram_1rw_req_adapter

Overview:
- Request-side front end for the 32x2048 single-port SRAM macro.
- Converts a valid/ready request channel (read/write, byte enables) into the macro's ce/we/addr/wd/w_mask pins.
- Captures the macro's read data, one cycle after the access, into a 2-entry response FIFO with valid/ready backpressure.
- Sits directly upstream of the macro: every macro input is driven from this block, and macro rd_out is consumed only here.

Parameters:
- DW, 32, data width; must equal the macro BITS.
- AW, 11, word address width; must equal the macro ADDR_WIDTH.
- DEPTH, 2048, number of words; equals 2**AW.
- RSP_DEPTH, 2, response FIFO entries; also the maximum number of outstanding reads.

Ports:
- clk_i  input  1  clock; also drives the macro clk.
- rst_ni  input  1  asynchronous active-low reset.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  request accepted this cycle when high together with req_valid_i.
- req_we_i  input  1  1 = write, 0 = read.
- req_addr_i  input  AW  word address.
- req_wdata_i  input  DW  write data.
- req_be_i  input  DW/8  byte enables; write only.
- rsp_valid_o  output  1  read data available.
- rsp_ready_i  input  1  consumer takes the response.
- rsp_rdata_o  output  DW  read data.
- init_done_o  output  1  block is ready for traffic.
- sram_ce_o  output  1  to macro ce_in.
- sram_we_o  output  1  to macro we_in.
- sram_addr_o  output  AW  to macro addr_in.
- sram_wd_o  output  DW  to macro wd_in.
- sram_wmask_o  output  DW  to macro w_mask_in.
- sram_rd_i  input  DW  from macro rd_out.

Behaviour:
- Reset values: FIFO empty, rd_pend=0, rsp_valid_o=0, rsp_rdata_o=0.
- init_done_o resets to 1 without the optional feature and to 0 with it.
- acc = req_valid_i & req_ready_o.
- Macro pins are combinational from the request:
  - sram_ce_o = acc.
  - sram_we_o = req_we_i.
  - sram_addr_o = req_addr_i.
  - sram_wd_o = req_wdata_i.
  - sram_wmask_o[i] = req_be_i[i/8] for writes; all-ones for reads.
  - When acc=0, sram_ce_o=0 and the other macro pins hold 0.
- The macro samples at the edge ending the accept cycle N.
- Write: complete at that edge; no response is generated.
- Read: rd_pend is set at edge N. During cycle N+1, sram_rd_i is valid and is pushed into the FIFO at edge N+1. rsp_valid_o rises in cycle N+2 (latency 2).
- pop = rsp_valid_o & rsp_ready_i. The FIFO is in-order with registered output; rsp_rdata_o is the head entry.
- Credit rule, with outst = rd_pend + fifo_count:
  - A read is allowed when outst - pop < RSP_DEPTH.
  - A write is allowed whenever init_done_o=1.
  - req_ready_o = init_done_o & (req_we_i | read allowed).
  - With rsp_ready_i held high, reads sustain one per cycle; the FIFO can never overflow.
- Simultaneous push and pop keeps the count constant; a pop on an empty FIFO is impossible because rsp_valid_o=0.
- req_ready_o may depend on req_we_i and rsp_ready_i combinationally. req_valid_i must not depend on req_ready_o.
- No range check: AW covers DEPTH exactly.
- Reset assertion mid-operation: the FIFO and rd_pend clear immediately and any in-flight read is dropped. sram_ce_o is forced to 0 while rst_ni=0.

Optional Feature:
- Macro: SRAM_ZERO_INIT_EN.
- Defined:
  - After reset release, an AW-bit counter sweeps addresses 0..DEPTH-1, one per cycle.
  - Each sweep cycle drives sram_ce_o=1, sram_we_o=1, wd=0, wmask=all-ones.
  - req_ready_o stays 0 during the sweep.
  - init_done_o rises in the cycle after address DEPTH-1 is written, i.e. DEPTH cycles after reset release.
  - Reset during the sweep restarts it at address 0.
- Undefined: no counter; init_done_o=1 from reset and all words power up undefined.

Test Plan:
- Write 0xDEADBEEF to addr 0x005 with be=4'hF, then read 0x005 with rsp_ready=1 -> sram_ce_o pulses once per accept; rsp_valid_o two cycles after the read accept with rdata 0xDEADBEEF.
- Byte mask: write 0x11223344 with be=4'b0101 over a word holding 0xAAAAAAAA -> sram_wmask_o=0x00FF00FF; read returns 0xAA22AA44.
- Back-to-back reads of addrs 1,2,3,4 with rsp_ready=1 -> req_ready_o stays 1 and responses arrive in order on consecutive cycles.
- rsp_ready=0 and reads issued every cycle -> two reads accepted, then req_ready_o=0 for reads while writes remain accepted. Raise rsp_ready -> both buffered responses drain in order and reads resume with no loss.
- Assert rst_ni with one read pending and FIFO count 1 -> rsp_valid_o=0 and sram_ce_o=0 immediately; after release, no stale response appears.
- With SRAM_ZERO_INIT_EN: release reset -> init_done_o=0 for 2048 cycles with sram_ce_o=sram_we_o=1 and addresses 0..2047; afterwards, reading 0x7FF returns 0x00000000.

Source files
------------

// File: rtl/sram_1rw_req_adapter.sv
// sram_1rw_req_adapter
// Request-side front end for the 32x2048 single-port SRAM macro. Turns a
// valid/ready read/write request channel into the macro pins and returns
// read data through a small in-order response FIFO with credit-based flow
// control, so the FIFO can never overflow.
//
// Optional build macro SRAM_ZERO_INIT_EN: when defined, the block sweeps
// every address writing zero after reset release and holds off traffic
// (init_done_o=0) until the sweep completes.
module sram_1rw_req_adapter #(
    parameter int DW        = 32,
    parameter int AW        = 11,
    parameter int DEPTH     = 2048,
    parameter int RSP_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [AW-1:0]   req_addr_i,
    input  logic [DW-1:0]   req_wdata_i,
    input  logic [DW/8-1:0] req_be_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [DW-1:0]   rsp_rdata_o,
    output logic            init_done_o,
    output logic            sram_ce_o,
    output logic            sram_we_o,
    output logic [AW-1:0]   sram_addr_o,
    output logic [DW-1:0]   sram_wd_o,
    output logic [DW-1:0]   sram_wmask_o,
    input  logic [DW-1:0]   sram_rd_i
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic            acc;
    logic            pop;
    logic            push;
    logic            rd_pend;
    logic            read_ok;
    logic            sweeping;
    logic [AW-1:0]   sweep_addr;
    logic [CW-1:0]   count;
    logic [CW:0]     outst;
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [DW-1:0]   fifo_mem [RSP_DEPTH];

`ifdef SRAM_ZERO_INIT_EN
    logic            init_done;
    logic [AW-1:0]   sweep_cnt;

    // Zero-fill sweep: one address per cycle, done after the last word is written
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            init_done <= 1'b0;
            sweep_cnt <= '0;
        end else if (!init_done) begin
            sweep_cnt <= sweep_cnt + AW'(1);
            if (sweep_cnt == AW'(DEPTH - 1)) begin
                init_done <= 1'b1;
            end
        end
    end

    assign init_done_o = init_done;
    assign sweeping    = ~init_done;
    assign sweep_addr  = sweep_cnt;
`else
    assign init_done_o = 1'b1;
    assign sweeping    = 1'b0;
    assign sweep_addr  = '0;
`endif

    // Credits: in-flight read plus buffered responses, freed early by a pop this cycle
    assign pop     = rsp_valid_o & rsp_ready_i;
    assign push    = rd_pend;
    assign outst   = {1'b0, count} + (CW+1)'(rd_pend);
    assign read_ok = (outst - (CW+1)'(pop)) < (CW+1)'(RSP_DEPTH);

    assign req_ready_o = init_done_o & (req_we_i | read_ok);
    assign acc         = req_valid_i & req_ready_o;

    // Macro pin drive: sweep has priority, otherwise the accepted request; idle pins are zero
    always_comb begin
        sram_ce_o    = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wd_o    = '0;
        sram_wmask_o = '0;
        if (rst_ni) begin
            if (sweeping) begin
                sram_ce_o    = 1'b1;
                sram_we_o    = 1'b1;
                sram_addr_o  = sweep_addr;
                sram_wmask_o = '1;
            end else if (acc) begin
                sram_ce_o   = 1'b1;
                sram_we_o   = req_we_i;
                sram_addr_o = req_addr_i;
                sram_wd_o   = req_wdata_i;
                for (int i = 0; i < DW; i++) begin
                    sram_wmask_o[i] = req_we_i ? req_be_i[i/8] : 1'b1;
                end
            end
        end
    end

    // Remember an accepted read so its macro data is captured on the next edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= acc & ~req_we_i;
        end
    end

    // In-order response FIFO; head entry is presented directly on rsp_rdata_o
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wptr] <= sram_rd_i;
                wptr <= (wptr == PW'(RSP_DEPTH - 1)) ? '0 : wptr + PW'(1);
            end
            if (pop) begin
                rptr <= (rptr == PW'(RSP_DEPTH - 1)) ? '0 : rptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rsp_valid_o = (count != '0);
    assign rsp_rdata_o = fifo_mem[rptr];

endmodule
